mips_mem_subsys: RTL and testbench

//  Parametrised memory subsystem for the MIPS core: instruction RAM, data RAM and a program-loader port behind one block.

---
 rtl/mips_mem_subsys.sv | 156 +++++++++++++++
 tb/tb_mips_mem_subsys.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_subsys.sv
// Instruction RAM, data RAM and program-loader port for the MIPS core.
// The core is held off the memories while a program is being loaded.
module mips_mem_subsys #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int INSTR_W       = 32,
    parameter int IM_DEPTH      = 256,
    parameter int DM_DEPTH      = 256,
    parameter bit LOAD_ON_RESET = 1'b1,
    parameter bit RDW_NEW       = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               im_rden,
    input  logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_q,
    output logic               im_valid,
    input  logic               dm_rden,
    input  logic [ADDR_W-1:0]  dm_rdaddr,
    output logic [DATA_W-1:0]  dm_rdata,
    output logic               dm_rvalid,
    input  logic               dm_wren,
    input  logic [ADDR_W-1:0]  dm_wraddr,
    input  logic [DATA_W-1:0]  dm_wdata,
    output logic               cpu_hold,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_ready,
    input  logic               ld_done,
    output logic [ADDR_W:0]    ld_count,
    output logic               dm_err,
    input  logic               err_clr
);

    localparam int IM_IDX_W = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
    localparam int DM_IDX_W = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
    localparam logic [ADDR_W:0] IM_LIMIT  = IM_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] DM_LIMIT  = DM_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD
    } state_t;

    localparam state_t RESET_STATE = LOAD_ON_RESET ? ST_LOAD : ST_RUN;

    state_t               state_reg, state_next;
    logic [ADDR_W:0]      count_reg, count_next;
    logic                 err_reg, err_next;
    logic [INSTR_W-1:0]   im_q_reg;
    logic                 im_valid_reg;
    logic [DATA_W-1:0]    dm_rdata_reg;
    logic                 dm_rvalid_reg;

    logic [INSTR_W-1:0]   im_mem [IM_DEPTH];
    logic [DATA_W-1:0]    dm_mem [DM_DEPTH];

    logic                 hold;
    logic                 im_acc, dm_rd_acc, dm_wr_acc, ld_acc;
    logic                 im_in, dm_rd_in, dm_wr_in, ld_in;
    logic                 err_set;
    logic [IM_IDX_W-1:0]  im_idx, ld_idx;
    logic [DM_IDX_W-1:0]  dm_rd_idx, dm_wr_idx;
    logic [DATA_W-1:0]    dm_rd_word;

    assign hold      = (state_reg != ST_RUN);
    assign cpu_hold  = hold;
    assign ld_ready  = (state_reg == ST_LOAD);

    // Core requests are dropped entirely while held; loader only acts in LOAD.
    assign im_acc    = im_rden & ~hold;
    assign dm_rd_acc = dm_rden & ~hold;
    assign dm_wr_acc = dm_wren & ~hold;
    assign ld_acc    = ld_valid & ld_ready;

    assign im_in     = ({1'b0, im_addr}   < IM_LIMIT);
    assign dm_rd_in  = ({1'b0, dm_rdaddr} < DM_LIMIT);
    assign dm_wr_in  = ({1'b0, dm_wraddr} < DM_LIMIT);
    assign ld_in     = ({1'b0, ld_addr}   < IM_LIMIT);

    assign im_idx    = im_addr[IM_IDX_W-1:0];
    assign ld_idx    = ld_addr[IM_IDX_W-1:0];
    assign dm_rd_idx = dm_rdaddr[DM_IDX_W-1:0];
    assign dm_wr_idx = dm_wraddr[DM_IDX_W-1:0];

    assign err_set = (im_acc & ~im_in) | (dm_rd_acc & ~dm_rd_in)
                   | (dm_wr_acc & ~dm_wr_in) | (ld_acc & ~ld_in);

    generate
        if (RDW_NEW) begin : g_rdw_new
            // An out-of-range write can only match an out-of-range read, which returns 0 anyway.
            assign dm_rd_word = (dm_wr_acc && (dm_wraddr == dm_rdaddr))
                              ? dm_wdata : dm_mem[dm_rd_idx];
        end else begin : g_rdw_old
            assign dm_rd_word = dm_mem[dm_rd_idx];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_RUN:   if (ld_start) state_next = ST_DRAIN;
            ST_DRAIN: begin
                state_next = ST_LOAD;
                count_next = '0;
            end
            ST_LOAD: begin
                if (ld_done) state_next = ST_RUN;
                if (ld_acc && (count_reg != COUNT_MAX)) count_next = count_reg + 1'b1;
            end
            default:  state_next = RESET_STATE;
        endcase
        if (err_set)      err_next = 1'b1;
        else if (err_clr) err_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RESET_STATE;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            im_q_reg      <= '0;
            im_valid_reg  <= 1'b0;
            dm_rdata_reg  <= '0;
            dm_rvalid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            err_reg       <= err_next;
            im_valid_reg  <= im_acc;
            dm_rvalid_reg <= dm_rd_acc;
            if (im_acc)    im_q_reg     <= im_in    ? im_mem[im_idx] : '0;
            if (dm_rd_acc) dm_rdata_reg <= dm_rd_in ? dm_rd_word     : '0;
        end
    end

    // RAM arrays carry no reset so contents survive a reset mid-load.
    always_ff @(posedge clk) begin
        if (ld_acc && ld_in)       im_mem[ld_idx]    <= ld_data;
        if (dm_wr_acc && dm_wr_in) dm_mem[dm_wr_idx] <= dm_wdata;
    end

    assign im_q      = im_q_reg;
    assign im_valid  = im_valid_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign dm_rvalid = dm_rvalid_reg;
    assign ld_count  = count_reg;
    assign dm_err    = err_reg;

endmodule

// File: tb/tb_mips_mem_subsys.sv
// Bench for mips_mem_subsys: directed scenarios plus random traffic, all
// checked every cycle against an array-based model of the memory subsystem.
module tb_mips_mem_subsys;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int INSTR_W  = 32;
    localparam int IM_DEPTH = 256;
    localparam int DM_DEPTH = 128;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               im_rden;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_q;
    logic               im_valid;
    logic               dm_rden;
    logic [ADDR_W-1:0]  dm_rdaddr;
    logic [DATA_W-1:0]  dm_rdata;
    logic               dm_rvalid;
    logic               dm_wren;
    logic [ADDR_W-1:0]  dm_wraddr;
    logic [DATA_W-1:0]  dm_wdata;
    logic               cpu_hold;
    logic               ld_start;
    logic               ld_valid;
    logic [ADDR_W-1:0]  ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_ready;
    logic               ld_done;
    logic [ADDR_W:0]    ld_count;
    logic               dm_err;
    logic               err_clr;

    mips_mem_subsys #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W),
        .IM_DEPTH(IM_DEPTH), .DM_DEPTH(DM_DEPTH),
        .LOAD_ON_RESET(1'b1), .RDW_NEW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .im_rden(im_rden), .im_addr(im_addr), .im_q(im_q), .im_valid(im_valid),
        .dm_rden(dm_rden), .dm_rdaddr(dm_rdaddr), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
        .dm_wren(dm_wren), .dm_wraddr(dm_wraddr), .dm_wdata(dm_wdata),
        .cpu_hold(cpu_hold),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count),
        .dm_err(dm_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: memory contents with "known" flags, a mode (0 run, 1 drain, 2 load)
    // and the values every output should show during the current cycle.
    logic [INSTR_W-1:0] im_m [IM_DEPTH];
    bit                 im_k [IM_DEPTH];
    logic [DATA_W-1:0]  dm_m [DM_DEPTH];
    bit                 dm_k [DM_DEPTH];
    int                 m_mode;
    logic [INSTR_W-1:0] e_im_q;
    bit                 e_im_qk;
    bit                 e_imv;
    logic [DATA_W-1:0]  e_dm;
    bit                 e_dmk;
    bit                 e_dmv;
    int                 e_count;
    bit                 e_err;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endfunction

    function automatic void model_reset();
        m_mode  = 2;
        e_im_q  = '0; e_im_qk = 1'b1; e_imv = 1'b0;
        e_dm    = '0; e_dmk   = 1'b1; e_dmv = 1'b0;
        e_count = 0;
        e_err   = 1'b0;
    endfunction

    function automatic void model_step();
        bit hold = (m_mode != 0);
        bit set  = 1'b0;
        e_imv = 1'b0;
        e_dmv = 1'b0;
        if (!hold && im_rden) begin
            e_imv = 1'b1;
            if (im_addr < IM_DEPTH) begin
                e_im_q = im_m[im_addr]; e_im_qk = im_k[im_addr];
            end else begin
                e_im_q = '0; e_im_qk = 1'b1; set = 1'b1;
            end
        end
        if (!hold && dm_rden) begin
            e_dmv = 1'b1;
            if (dm_rdaddr >= DM_DEPTH) begin
                e_dm = '0; e_dmk = 1'b1; set = 1'b1;
            end else if (dm_wren && dm_wraddr == dm_rdaddr) begin
                e_dm = dm_wdata; e_dmk = 1'b1;
            end else begin
                e_dm = dm_m[dm_rdaddr]; e_dmk = dm_k[dm_rdaddr];
            end
        end
        if (!hold && dm_wren) begin
            if (dm_wraddr < DM_DEPTH) begin
                dm_m[dm_wraddr] = dm_wdata; dm_k[dm_wraddr] = 1'b1;
            end else set = 1'b1;
        end
        if (m_mode == 2 && ld_valid) begin
            if (ld_addr < IM_DEPTH) begin
                im_m[ld_addr] = ld_data; im_k[ld_addr] = 1'b1;
            end else set = 1'b1;
            if (e_count < (1 << ADDR_W)) e_count++;
        end
        if (set)          e_err = 1'b1;
        else if (err_clr) e_err = 1'b0;
        case (m_mode)
            0: if (ld_start) m_mode = 1;
            1: begin m_mode = 2; e_count = 0; end
            default: if (ld_done) m_mode = 0;
        endcase
    endfunction

    function automatic void compare_all();
        chk("cpu_hold",  cpu_hold,  (m_mode != 0));
        chk("ld_ready",  ld_ready,  (m_mode == 2));
        chk("ld_count",  ld_count,  32'(e_count));
        chk("dm_err",    dm_err,    e_err);
        chk("im_valid",  im_valid,  e_imv);
        chk("dm_rvalid", dm_rvalid, e_dmv);
        if (e_im_qk) chk("im_q", im_q, e_im_q);
        if (e_dmk)   chk("dm_rdata", dm_rdata, e_dm);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        im_rden = 0; im_addr = '0;
        dm_rden = 0; dm_rdaddr = '0;
        dm_wren = 0; dm_wraddr = '0; dm_wdata = '0;
        ld_start = 0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_done = 0;
        err_clr = 0;
    endtask

    initial begin
        logic [INSTR_W-1:0] words [3];
        words[0] = 32'hC0DE0000; words[1] = 32'hC0DE0001; words[2] = 32'hC0DE0002;

        idle();
        reset_n = 1'b0;
        model_reset();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rst_hold", cpu_hold, 1);
        chk("rst_ready", ld_ready, 1);
        chk("rst_count", ld_count, 0);

        // Load two words, release the core, fetch one back
        ld_valid = 1; ld_addr = 8'h00; ld_data = 32'h20010005; tick();
        ld_addr = 8'h01; ld_data = 32'h00221820; tick();
        idle(); ld_done = 1; tick();
        idle();
        chk("t1_count", ld_count, 2);
        chk("t1_hold", cpu_hold, 0);
        im_rden = 1; im_addr = 8'h01; tick();
        idle();
        chk("t1_im_q", im_q, 32'h00221820);
        chk("t1_im_valid", im_valid, 1);
        tick();
        chk("t1_valid_pulse", im_valid, 0);

        // DM write then read, then same-cycle write+read
        dm_wren = 1; dm_wraddr = 8'h10; dm_wdata = 8'hA5; tick();
        idle(); dm_rden = 1; dm_rdaddr = 8'h10; tick();
        chk("t2_rdata", dm_rdata, 8'hA5);
        chk("t2_rvalid", dm_rvalid, 1);
        idle(); dm_wren = 1; dm_wraddr = 8'h10; dm_wdata = 8'h3C;
        dm_rden = 1; dm_rdaddr = 8'h10; tick();
        chk("t2_rdw_new", dm_rdata, 8'h3C);

        // Out-of-range DM access and sticky error
        idle(); dm_wren = 1; dm_wraddr = 8'h80; dm_wdata = 8'h77; tick();
        chk("t3_err_wr", dm_err, 1);
        idle(); dm_rden = 1; dm_rdaddr = 8'h80; tick();
        chk("t3_rdata_zero", dm_rdata, 0);
        chk("t3_rvalid", dm_rvalid, 1);
        idle(); err_clr = 1; dm_rden = 1; dm_rdaddr = 8'h90; tick();
        chk("t3_set_wins", dm_err, 1);
        idle(); err_clr = 1; tick();
        chk("t3_cleared", dm_err, 0);

        // Loader ignored in RUN; read in the ld_start cycle completes in DRAIN
        idle(); ld_valid = 1; ld_addr = 8'h00; ld_data = 32'hDEADBEEF; tick();
        idle(); dm_rden = 1; dm_rdaddr = 8'h05; ld_start = 1; tick();
        chk("t4_drain_rvalid", dm_rvalid, 1);
        chk("t4_drain_hold", cpu_hold, 1);
        idle(); dm_rden = 1; dm_rdaddr = 8'h10; im_rden = 1; im_addr = 8'h01; tick();
        chk("t4_no_dm_valid", dm_rvalid, 0);
        chk("t4_no_im_valid", im_valid, 0);
        chk("t4_load_ready", ld_ready, 1);

        // Three words, then a reset pulse mid-load
        for (int i = 0; i < 3; i++) begin
            idle(); ld_valid = 1; ld_addr = 8'(8'h40 + i); ld_data = words[i]; tick();
        end
        chk("t5_count3", ld_count, 3);
        idle();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_count", ld_count, 0);
        chk("t5_rst_hold", cpu_hold, 1);
        chk("t5_rst_ready", ld_ready, 1);
        tick();
        reset_n = 1'b1;
        ld_done = 1; tick();
        for (int i = 0; i < 3; i++) begin
            idle(); im_rden = 1; im_addr = 8'(8'h40 + i); tick();
            chk("t5_retained", im_q, words[i]);
        end
        idle(); im_rden = 1; im_addr = 8'h00; tick();
        chk("t4_im_unchanged", im_q, 32'h20010005);

        // Long load: counter saturates at 2**ADDR_W, IM fully initialised
        idle(); ld_start = 1; tick();
        idle(); tick();
        for (int i = 0; i < 260; i++) begin
            ld_valid = 1; ld_addr = 8'(i); ld_data = $urandom; tick();
        end
        chk("t6_saturate", ld_count, 32'h100);
        idle(); ld_done = 1; tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            im_rden   = $urandom_range(0, 1);
            im_addr   = 8'($urandom);
            dm_rden   = $urandom_range(0, 1);
            dm_rdaddr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            dm_wren   = $urandom_range(0, 1);
            dm_wraddr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            dm_wdata  = 8'($urandom);
            ld_start  = ($urandom_range(0, 29) == 0);
            ld_valid  = $urandom_range(0, 1);
            ld_addr   = 8'($urandom);
            ld_data   = $urandom;
            ld_done   = ($urandom_range(0, 14) == 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
